// File: rtl/tm1638_frame_scheduler.sv
// TM1638 frame scheduler: periodic mode/display/brightness/key-scan
// byte sequence toward a byte-level serial engine.

module tm1638_frame_scheduler #(
  parameter int clk_mhz    = 27,
  parameter int refresh_hz = 500,
  parameter int w_digit    = 8,
  parameter int brightness = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [8*w_digit-1:0] seg_data,
  input  logic [w_digit-1:0]   led,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  output logic                 byte_dir,
  output logic                 byte_last,
  input  logic                 byte_ready,
  input  logic                 rd_valid,
  input  logic [7:0]           rd_data,
  output logic [7:0]           keys,
  output logic                 keys_valid,
  output logic                 busy
);

  localparam int P  = clk_mhz * 1_000_000 / refresh_hz;
  localparam int TW = (P > 1) ? $clog2(P) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(P - 1);
  localparam logic [2:0] BRI = 3'(brightness);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MODE,
    S_ADDR,
    S_DATA,
    S_DISP,
    S_RCMD,
    S_RREQ,
    S_RWAIT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [TW-1:0]        timer;
  logic                 tick;
  logic                 pending;
  logic                 start;
  logic [8*w_digit-1:0] seg_q;
  logic [w_digit-1:0]   led_q;
  logic [3:0]           idx;
  logic [1:0]           rcnt;
  logic [7:0]           key_acc;
  logic                 rd_take;
  logic [7:0][7:0]      seg_pad;
  logic [7:0]           led_pad;
  logic [7:0]           data_byte;

  // Unused digit positions read as blank so the display RAM is cleared.
  for (genvar j = 0; j < 8; j++) begin : g_pad
    if (j < w_digit) begin : g_use
      assign seg_pad[j] = seg_q[8*j +: 8];
      assign led_pad[j] = led_q[j];
    end else begin : g_zero
      assign seg_pad[j] = 8'h00;
      assign led_pad[j] = 1'b0;
    end
  end

  assign data_byte = idx[0] ? {7'b0, led_pad[idx[3:1]]}
                            : seg_pad[idx[3:1]];

  assign tick       = (timer == T_LAST);
  assign rd_take    = (state == S_RWAIT) && rd_valid;
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign keys_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_dir   = 1'b0;
    byte_last  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pending && enable) begin
          start   = 1'b1;
          state_n = S_MODE;
        end
      end
      S_MODE: begin
        byte_valid = 1'b1;
        byte_data  = 8'h40;
        byte_last  = 1'b1;
        if (byte_ready) state_n = S_ADDR;
      end
      S_ADDR: begin
        byte_valid = 1'b1;
        byte_data  = 8'hC0;
        if (byte_ready) state_n = S_DATA;
      end
      S_DATA: begin
        byte_valid = 1'b1;
        byte_data  = data_byte;
        byte_last  = (idx == 4'd15);
        if (byte_ready && idx == 4'd15) state_n = S_DISP;
      end
      S_DISP: begin
        byte_valid = 1'b1;
        byte_data  = 8'h88 | {5'b0, BRI};
        byte_last  = 1'b1;
        if (byte_ready) state_n = S_RCMD;
      end
      S_RCMD: begin
        byte_valid = 1'b1;
        byte_data  = 8'h42;
        if (byte_ready) state_n = S_RREQ;
      end
      S_RREQ: begin
        byte_valid = 1'b1;
        byte_dir   = 1'b1;
        byte_last  = (rcnt == 2'd3);
        if (byte_ready) state_n = S_RWAIT;
      end
      S_RWAIT: begin
        if (rd_valid) begin
          state_n = (rcnt == 2'd3) ? S_DONE : S_RREQ;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      pending <= 1'b0;
      seg_q   <= '0;
      led_q   <= '0;
      idx     <= '0;
      rcnt    <= '0;
      key_acc <= '0;
      keys    <= '0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      // A tick in the consuming cycle still counts as a new request.
      pending <= tick | (pending & ~start);
      if (start) begin
        seg_q <= seg_data;
        led_q <= led;
        idx   <= '0;
        rcnt  <= '0;
      end
      if (state == S_DATA && byte_ready) begin
        idx <= idx + 4'd1;
      end
      if (rd_take) begin
        key_acc[{1'b0, rcnt}] <= rd_data[0];
        key_acc[{1'b1, rcnt}] <= rd_data[4];
        rcnt <= rcnt + 2'd1;
        if (rcnt == 2'd3) begin
          keys <= {rd_data[4], key_acc[6:4],
                   rd_data[0], key_acc[2:0]};
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_frame_scheduler.sv
// Bench for tm1638_frame_scheduler: directed byte-order tables,
// multi-cycle corner sequences and a randomized transaction model.

module tb_tm1638_frame_scheduler;

  localparam int P = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] seg = '0;
  logic [7:0]  led = '0;
  logic [31:0] seg4 = '0;
  logic [3:0]  led4 = '0;
  logic        byte_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_data = '0;

  logic       bv8, bdir8, bl8, kv8, busy8;
  logic [7:0] bd8, keys8;
  logic       bv4, bdir4, bl4, kv4, busy4;
  logic [7:0] bd4, keys4;

  always #5 clk = ~clk;

  tm1638_frame_scheduler #(
    .clk_mhz(1), .refresh_hz(100000), .w_digit(8), .brightness(7)
  ) u8 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .seg_data(seg), .led(led),
    .byte_valid(bv8), .byte_data(bd8), .byte_dir(bdir8),
    .byte_last(bl8), .byte_ready(byte_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .keys(keys8), .keys_valid(kv8), .busy(busy8)
  );

  tm1638_frame_scheduler #(
    .clk_mhz(1), .refresh_hz(100000), .w_digit(4), .brightness(7)
  ) u4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .seg_data(seg4), .led(led4),
    .byte_valid(bv4), .byte_data(bd4), .byte_dir(bdir4),
    .byte_last(bl4), .byte_ready(byte_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .keys(keys4), .keys_valid(kv4), .busy(busy4)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d8;
    logic [7:0] d4;
    logic       dir;
    logic       last;
  } vec_t;

  vec_t       tbl[24];
  logic [9:0] got8[24];
  logic [9:0] got4[24];
  logic [7:0] rdv[4];
  int         n8, n4, nr, kvc, cnt, busyc, rises;
  logic       pend_rd = 1'b0;
  logic       prev, got;
  logic [9:0] first;

  // Reference model state (transaction level)
  int         m_timer, m_req, m_nrd;
  logic       m_pend, m_busy, m_wait, m_done, tk, consume, ev;
  logic [9:0] m_exp[24];
  logic [7:0] m_rd[4];
  logic [7:0] m_keys;
  logic [20:0] act_v, exp_v;

  task automatic serve();
    rd_valid = pend_rd;
    rd_data  = 8'($urandom);
    pend_rd  = bv8 & byte_ready & bdir8;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rd_valid = 1'b0;
    pend_rd = 1'b0;
    byte_ready = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic build(input logic [63:0] s, input logic [7:0] l);
    m_exp[0] = {2'b01, 8'h40};
    m_exp[1] = {2'b00, 8'hC0};
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      int k;
      k = i / 2;
      d = (i % 2 == 1) ? {7'b0, l[k]} : s[8*k +: 8];
      m_exp[2+i] = {1'b0, (i == 15), d};
    end
    m_exp[18] = {2'b01, 8'h8F};
    m_exp[19] = {2'b00, 8'h42};
    for (int j = 0; j < 4; j++) m_exp[20+j] = {1'b1, (j == 3), 8'h00};
  endtask

  initial begin
    tbl[0] = '{d8: 8'h40, d4: 8'h40, dir: 1'b0, last: 1'b1};
    tbl[1] = '{d8: 8'hC0, d4: 8'hC0, dir: 1'b0, last: 1'b0};
    for (int i = 0; i < 16; i++) begin
      tbl[2+i].d8   = (i == 0) ? 8'hFC : (i == 1) ? 8'h01 : 8'h00;
      tbl[2+i].d4   = (i >= 8) ? 8'h00 : (i % 2 == 0) ? 8'hFF : 8'h01;
      tbl[2+i].dir  = 1'b0;
      tbl[2+i].last = (i == 15);
    end
    tbl[18] = '{d8: 8'h8F, d4: 8'h8F, dir: 1'b0, last: 1'b1};
    tbl[19] = '{d8: 8'h42, d4: 8'h42, dir: 1'b0, last: 1'b0};
    for (int j = 0; j < 4; j++)
      tbl[20+j] = '{d8: 8'h00, d4: 8'h00, dir: 1'b1, last: (j == 3)};
    rdv[0] = 8'h01; rdv[1] = 8'h10; rdv[2] = 8'h00; rdv[3] = 8'h11;

    // Directed frame: byte order, digit limit, key packing
    seg  = 64'h00000000_000000FC;
    led  = 8'h01;
    seg4 = 32'hFFFFFFFF;
    led4 = 4'hF;
    #23;
    chk("reset_outputs", {bv8, bd8, bdir8, bl8, keys8, kv8, busy8}, 0);
    chk("reset_outputs_w4", {bv4, bd4, bdir4, bl4, keys4, kv4, busy4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    byte_ready = 1'b1;
    n8 = 0; n4 = 0; nr = 0; kvc = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      rd_valid = pend_rd;
      if (pend_rd && nr < 4) begin
        rd_data = rdv[nr];
        nr++;
      end
      pend_rd = bv8 & byte_ready & bdir8;
      if (bv8 && byte_ready && n8 < 24) begin
        got8[n8] = {bdir8, bl8, bd8};
        n8++;
        enable = 1'b0;
      end
      if (bv4 && byte_ready && n4 < 24) begin
        got4[n4] = {bdir4, bl4, bd4};
        n4++;
      end
      if (kv8) begin
        kvc++;
        chk("keys", keys8, 8'hA9);
        chk("busy_low_at_keys_valid", busy8, 0);
      end
      if (kv4) chk("keys_w4", keys4, 8'hA9);
    end
    chk("byte_count", n8, 24);
    chk("byte_count_w4", n4, 24);
    chk("keys_valid_pulses", kvc, 1);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("byte8_%0d", i), got8[i],
          {tbl[i].dir, tbl[i].last, tbl[i].d8});
      chk($sformatf("byte4_%0d", i), got4[i],
          {tbl[i].dir, tbl[i].last, tbl[i].d4});
    end

    // Stalled frame with several ticks, enable low: one more frame only
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy8) break;
    end
    chk("stall_frame_start", busy8, 1);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    chk("stall_hold", {bv8, bdir8, bl8, bd8}, {1'b1, 1'b0, 1'b1, 8'h40});
    byte_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      serve();
      if (kv8) begin
        got = 1'b1;
        break;
      end
    end
    chk("stalled_frame_done", got, 1);
    busyc = 0;
    repeat (50) begin
      @(negedge clk);
      serve();
      busyc += int'(busy8);
    end
    chk("idle_while_disabled", busyc, 0);
    enable = 1'b1;
    rises = 0;
    prev = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      enable = 1'b0;
      serve();
      if (busy8 && !prev) rises++;
      prev = busy8;
    end
    chk("one_frame_after_merge", rises, 1);

    // Asynchronous reset in the middle of the display data
    do_reset();
    enable = 1'b1;
    byte_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      serve();
      if (bv8 && byte_ready) cnt++;
      if (cnt == 8) break;
    end
    chk("reached_mid_data", cnt, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_mid_data",
        {bv8, bd8, bdir8, bl8, keys8, kv8, busy8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_valid = 1'b0;
    pend_rd = 1'b0;
    first = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      serve();
      if (bv8 && byte_ready) begin
        first = {bdir8, bl8, bd8};
        break;
      end
    end
    chk("restart_at_mode", first, {2'b01, 8'h40});

    // Randomized run against the transaction model
    do_reset();
    m_timer = 0; m_pend = 0; m_busy = 0; m_wait = 0; m_done = 0;
    m_req = 0; m_nrd = 0; m_keys = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ev = m_busy & ~m_wait;
      exp_v = {ev, ev ? m_exp[m_req] : 10'b0, m_busy, m_done, m_keys};
      act_v = {bv8, bv8 ? {bdir8, bl8, bd8} : 10'b0, busy8, kv8, keys8};
      chk($sformatf("random_cycle_%0d", cyc), act_v, exp_v);
      byte_ready = ($urandom_range(0, 9) < 3);
      rd_valid   = ($urandom_range(0, 9) < 4);
      rd_data    = 8'($urandom);
      enable     = ($urandom_range(0, 9) != 0);
      seg        = {$urandom, $urandom};
      led        = 8'($urandom);
      tk = (m_timer == P - 1);
      m_timer = (m_timer + 1) % P;
      consume = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (m_pend && enable) begin
          consume = 1'b1;
          build(seg, led);
          m_busy = 1'b1; m_wait = 1'b0; m_req = 0; m_nrd = 0;
        end
      end else if (!m_wait) begin
        if (byte_ready) begin
          if (m_req >= 20) m_wait = 1'b1;
          m_req++;
        end
      end else if (rd_valid) begin
        m_rd[m_nrd] = rd_data;
        m_nrd++;
        m_wait = 1'b0;
        if (m_nrd == 4) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          for (int i = 0; i < 4; i++) begin
            m_keys[i]   = m_rd[i][0];
            m_keys[i+4] = m_rd[i][4];
          end
        end
      end
      m_pend = tk | (m_pend & ~consume);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
